// File: rtl/mau_pkg.sv
// Shared types and constants for the mem_access_unit slice: access-size
// encodings, FSM states and the data word width.
package mau_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        HOLD,
        RESP
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the core memory stage (master) and the
// load/store unit (slave).
interface mem_access_unit_if;
    import mau_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: extracts and extends sub-word loads, and
// merges sub-word store data into the previously read word (little-endian).
module mem_lane_align
    import mau_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    logic [4:0]        shamt;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] lane_mask;
    logic [WORD_W-1:0] lane_data;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        load_data = word;
        lane_mask = '1;
        lane_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
                lane_data = {24'h0, wdata[7:0]} << shamt;
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
                lane_data = {16'h0, wdata[15:0]} << shamt;
            end
            default: begin
                load_data = word;
                lane_mask = '1;
                lane_data = wdata;
            end
        endcase
        merge_data = (old_word & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed MemRAM. Byte/half accesses
// (read-modify-write stores) exist only when MAU_SUBWORD_EN is defined.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus,
    output logic              rEn,
    output logic              wEn,
    output logic [WORD_W-1:0] Adress,
    output logic [WORD_W-1:0] DataWrite,
    input  logic [WORD_W-1:0] DataRead
);

    mau_state_t state;
    logic       req_err;
    logic       out_of_range;

    assign out_of_range = 32'(bus.req_addr[31:2]) >= 32'(DEPTH);

`ifdef MAU_SUBWORD_EN
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] load_word;
    logic [WORD_W-1:0] merge_word;

    mem_lane_align u_align (
        .word       (DataRead),
        .offset     (off_q),
        .size       (size_q),
        .sign_ext   (signed_q),
        .old_word   (DataRead),
        .wdata      (wdata_q),
        .load_data  (load_word),
        .merge_data (merge_word)
    );

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'b11)
            req_err = 1'b1;
        else if (bus.req_size == SZ_HALF && bus.req_addr[0])
            req_err = 1'b1;
        else if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        else if (out_of_range)
            req_err = 1'b1;
    end
`else
    logic unused_signed;
    assign unused_signed = bus.req_signed;

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size != SZ_WORD)
            req_err = 1'b1;
        else if (bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        else if (out_of_range)
            req_err = 1'b1;
    end
`endif

    // rEn and wEn are only ever set in mutually exclusive states, and the RD->WR
    // hop clears rEn on the same edge that raises wEn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            rEn           <= 1'b0;
            wEn           <= 1'b0;
            Adress        <= '0;
            DataWrite     <= '0;
`ifdef MAU_SUBWORD_EN
            we_q          <= 1'b0;
            signed_q      <= 1'b0;
            size_q        <= SZ_WORD;
            off_q         <= 2'b00;
            wdata_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                        if (req_err) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            Adress <= {2'b00, bus.req_addr[31:2]};
`ifdef MAU_SUBWORD_EN
                            we_q     <= bus.req_we;
                            signed_q <= bus.req_signed;
                            size_q   <= bus.req_size;
                            off_q    <= bus.req_addr[1:0];
                            wdata_q  <= bus.req_wdata;
`endif
                            if (!bus.req_we) begin
                                rEn   <= 1'b1;
                                state <= RD;
                            end else if (bus.req_size == SZ_WORD) begin
                                DataWrite <= bus.req_wdata;
                                wEn       <= 1'b1;
                                state     <= WR;
                            end
`ifdef MAU_SUBWORD_EN
                            else begin
                                rEn   <= 1'b1;
                                state <= RD;
                            end
`endif
                        end
                    end
                end
                RD: begin
                    rEn <= 1'b0;
`ifdef MAU_SUBWORD_EN
                    if (we_q) begin
                        DataWrite <= merge_word;
                        wEn       <= 1'b1;
                        state     <= WR;
                    end else begin
                        bus.rsp_rdata <= load_word;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
`else
                    bus.rsp_rdata <= DataRead;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
`endif
                end
                WR: begin
                    wEn   <= 1'b0;
                    state <= HOLD;
                end
                HOLD: begin
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    rEn           <= 1'b0;
                    wEn           <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural MemRAM;
// sub-word scenarios follow MAU_SUBWORD_EN.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rEn;
    logic        wEn;
    logic [31:0] Adress;
    logic [31:0] DataWrite;
    logic [31:0] DataRead;

    mem_access_unit_if bus();

    mem_access_unit #(.DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rEn       (rEn),
        .wEn       (wEn),
        .Adress    (Adress),
        .DataWrite (DataWrite),
        .DataRead  (DataRead)
    );

    always #5 clk = ~clk;

    // Behavioural memory: reads return zero when rEn and wEn are equal.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_data = 32'h0;

    assign DataRead = (rEn && !wEn) ? mem[Adress[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (wEn)
            mem[Adress[7:0]] <= DataWrite;
        else if (pre_we)
            mem[pre_idx] <= pre_data;
    end

    int          cyc = 0;
    int          rd_total = 0;
    int          wr_total = 0;
    int          ovl_total = 0;
    int          hold_bad = 0;
    int          rsp_total = 0;
    int          rd_last = 0;
    int          wr_last = 0;
    logic        prev_wen = 1'b0;
    logic [31:0] wr_addr_s = 32'h0;
    logic [31:0] wr_data_s = 32'h0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rEn === 1'b1) begin
            rd_total = rd_total + 1;
            rd_last  = cyc;
        end
        if (prev_wen && (Adress !== wr_addr_s || DataWrite !== wr_data_s))
            hold_bad = hold_bad + 1;
        if (wEn === 1'b1) begin
            wr_total  = wr_total + 1;
            wr_last   = cyc;
            wr_addr_s = Adress;
            wr_data_s = DataWrite;
        end
        if (rEn === 1'b1 && wEn === 1'b1)
            ovl_total = ovl_total + 1;
        if (bus.rsp_valid === 1'b1)
            rsp_total = rsp_total + 1;
        prev_wen = (wEn === 1'b1);
    end

    int errors = 0;
    int checks = 0;

    int          r_lat;
    int          r_wait;
    int          r_rd;
    int          r_wr;
    int          r_ovl;
    int          r_hold;
    int          r_rdl;
    int          r_wrl;
    logic [31:0] r_rdata;
    logic        r_err;

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd);
        int rd0, wr0, ov0, hb0;
        @(negedge clk);
        r_wait = 0;
        while (bus.req_ready !== 1'b1 && r_wait < 20) begin
            @(negedge clk);
            r_wait++;
        end
        rd0 = rd_total; wr0 = wr_total; ov0 = ovl_total; hb0 = hold_bad;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_size   = 2'b11;
        bus.req_signed = ~sg;
        bus.req_addr   = ~addr;
        bus.req_wdata  = ~wd;
        r_lat = 1;
        while (bus.rsp_valid !== 1'b1 && r_lat < 12) begin
            @(negedge clk);
            r_lat++;
        end
        r_rdata = bus.rsp_rdata;
        r_err   = bus.rsp_err;
        r_rd    = rd_total - rd0;
        r_wr    = wr_total - wr0;
        r_ovl   = ovl_total - ov0;
        r_hold  = hold_bad - hb0;
        r_rdl   = rd_last;
        r_wrl   = wr_last;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_WORD;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", bus.rsp_err); end
        checks++; if (rEn !== 1'b0 || wEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got rEn=%b wEn=%b want 0/0", rEn, wEn); end
        checks++; if (Adress !== 32'h0) begin errors++; $display("[TB] FAIL reset_adress: got %h want 0", Adress); end
        checks++; if (DataWrite !== 32'h0) begin errors++; $display("[TB] FAIL reset_datawrite: got %h want 0", DataWrite); end
    endtask

    task automatic test_word_store();
        preload(8'd4, 32'h0);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (r_lat !== 3) begin errors++; $display("[TB] FAIL wst_latency: got %0d want 3", r_lat); end
        checks++; if (r_wr !== 1 || r_rd !== 0) begin errors++; $display("[TB] FAIL wst_en_cycles: got rd=%0d wr=%0d want 0/1", r_rd, r_wr); end
        checks++; if (wr_addr_s !== 32'd4) begin errors++; $display("[TB] FAIL wst_adress: got %h want 4", wr_addr_s); end
        checks++; if (wr_data_s !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wst_datawrite: got %h want deadbeef", wr_data_s); end
        checks++; if (r_hold !== 0) begin errors++; $display("[TB] FAIL wst_hold_stable: got %0d changes want 0", r_hold); end
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0) begin errors++; $display("[TB] FAIL wst_rsp: got err=%b rdata=%h want 0/0", r_err, r_rdata); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wst_mem: got %h want deadbeef", mem[4]); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wst_pulse: got rsp_valid=%b want 0", bus.rsp_valid); end
    endtask

    task automatic test_word_load();
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        checks++; if (r_lat !== 2) begin errors++; $display("[TB] FAIL wld_latency: got %0d want 2", r_lat); end
        checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wld_rdata: got %h want deadbeef", r_rdata); end
        checks++; if (r_rd !== 1 || r_wr !== 0 || r_err !== 1'b0) begin errors++; $display("[TB] FAIL wld_access: got rd=%0d wr=%0d err=%b want 1/0/0", r_rd, r_wr, r_err); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3] = '{32'h6, 32'h10, 32'h400};
        logic [1:0]  sizes [3] = '{SZ_WORD, 2'b11, SZ_WORD};
        logic        wes   [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_req(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF);
            checks++; if (r_lat !== 1) begin errors++; $display("[TB] FAIL err%0d_latency: got %0d want 1", i, r_lat); end
            checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("[TB] FAIL err%0d_rsp: got err=%b rdata=%h want 1/0", i, r_err, r_rdata); end
            checks++; if (r_rd !== 0 || r_wr !== 0) begin errors++; $display("[TB] FAIL err%0d_access: got rd=%0d wr=%0d want 0/0", i, r_rd, r_wr); end
        end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL err_mem: got %h want deadbeef", mem[4]); end
    endtask

`ifdef MAU_SUBWORD_EN
    task automatic test_subword();
        logic [31:0] ld_addr [5] = '{32'h13, 32'h13, 32'h12, 32'h11, 32'h10};
        logic [1:0]  ld_size [5] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_BYTE, SZ_BYTE};
        logic        ld_sg   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000012, 32'h00000034};
        preload(8'd4, 32'h80FF1234);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, ld_size[i], ld_sg[i], ld_addr[i], 32'h0);
            checks++; if (r_rdata !== ld_exp[i] || r_lat !== 2) begin errors++; $display("[TB] FAIL subld%0d: got %h lat %0d want %h lat 2", i, r_rdata, r_lat, ld_exp[i]); end
        end
        preload(8'd4, 32'h11223344);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h5555ABCD);
        checks++; if (r_lat !== 4) begin errors++; $display("[TB] FAIL hst_latency: got %0d want 4", r_lat); end
        checks++; if (r_rd !== 1 || r_wr !== 1 || r_ovl !== 0) begin errors++; $display("[TB] FAIL hst_en: got rd=%0d wr=%0d ovl=%0d want 1/1/0", r_rd, r_wr, r_ovl); end
        checks++; if (r_wrl !== r_rdl + 1) begin errors++; $display("[TB] FAIL hst_order: got wEn cycle %0d want %0d", r_wrl, r_rdl + 1); end
        checks++; if (mem[4] !== 32'hABCD3344) begin errors++; $display("[TB] FAIL hst_mem: got %h want abcd3344", mem[4]); end
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234565A);
        checks++; if (mem[4] !== 32'hABCD5A44 || r_lat !== 4) begin errors++; $display("[TB] FAIL bst_mem: got %h lat %0d want abcd5a44 lat 4", mem[4], r_lat); end
        do_req(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0);
        checks++; if (r_err !== 1'b1 || r_lat !== 1 || r_rd !== 0) begin errors++; $display("[TB] FAIL half_misalign: got err=%b lat %0d rd=%0d want 1/1/0", r_err, r_lat, r_rd); end
    endtask
`else
    task automatic test_subword();
        preload(8'd4, 32'h11223344);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h000000AA);
        checks++; if (r_err !== 1'b1 || r_lat !== 1) begin errors++; $display("[TB] FAIL nosub_bst: got err=%b lat %0d want 1 lat 1", r_err, r_lat); end
        checks++; if (r_rd !== 0 || r_wr !== 0 || mem[4] !== 32'h11223344) begin errors++; $display("[TB] FAIL nosub_bst_mem: got rd=%0d wr=%0d mem=%h want 0/0/11223344", r_rd, r_wr, mem[4]); end
        do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
        checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_rd !== 0) begin errors++; $display("[TB] FAIL nosub_hld: got err=%b rdata=%h rd=%0d want 1/0/0", r_err, r_rdata, r_rd); end
    endtask
`endif

    task automatic test_back_to_back();
        preload(8'd5, 32'h0);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h01020304);
        checks++; if (r_lat !== 3) begin errors++; $display("[TB] FAIL b2b_store_lat: got %0d want 3", r_lat); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
        checks++; if (r_wait !== 0) begin errors++; $display("[TB] FAIL b2b_ready: got %0d idle waits want 0", r_wait); end
        checks++; if (r_rdata !== 32'h01020304 || r_lat !== 2) begin errors++; $display("[TB] FAIL b2b_load: got %h lat %0d want 01020304 lat 2", r_rdata, r_lat); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0);
        checks++; if (r_wait !== 0 || r_err !== 1'b0 || r_lat !== 2) begin errors++; $display("[TB] FAIL b2b_last_word: got wait=%0d err=%b lat %0d want 0/0/2", r_wait, r_err, r_lat); end
    endtask

    task automatic test_reset_abort();
        int rsp0;
        preload(8'd8, 32'h11111111);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = SZ_WORD; bus.req_signed = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h22222222; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rsp0 = rsp_total;
        checks++; if (wEn !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_wr: got wEn=%b want 1", wEn); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (wEn !== 1'b0 || rEn !== 1'b0) begin errors++; $display("[TB] FAIL abort_async: got rEn=%b wEn=%b want 0/0", rEn, wEn); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rsp_total !== rsp0) begin errors++; $display("[TB] FAIL abort_no_rsp: got %0d responses want 0", rsp_total - rsp0); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b want 1", bus.req_ready); end
        checks++; if (mem[8] !== 32'h11111111 && mem[8] !== 32'h22222222) begin errors++; $display("[TB] FAIL abort_mem: got %h want 11111111 or 22222222", mem[8]); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        checks++; if (r_rdata !== mem[8] || r_lat !== 2) begin errors++; $display("[TB] FAIL abort_readback: got %h lat %0d want %h lat 2", r_rdata, r_lat, mem[8]); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_word_load();
        test_errors();
        test_subword();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
